lcd_text_writer: RTL and testbench

Sequences the LCD character display. After reset it issues the display configuration commands. Whenever the host has changed its 32-character text store, it then streams the full two-line screen contents as 10-bit command words into the LCDController command buffer. It sits between the host logic and the LCDController: `buffer_data` and `req_buff_write` drive that block directly, and its `full` output throttles this one. All LCD timing stays inside the LCDController. This block only orders and paces the words.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/char_store.sv | 28 ++
 rtl/lcd_text_writer.sv | 131 +++++++++++++
 tb/tb_lcd_text_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: command word field positions, LCD command bytes and the writer FSM encoding.
// Latency: none (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  localparam int RS_BIT = 9;
  localparam int RW_BIT = 8;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE0 = 8'h80;
  localparam logic [7:0] CMD_LINE1 = 8'hC0;

  typedef enum logic [2:0] {
    ST_CFG     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_L0_ADDR = 3'd2,
    ST_L0_CHR  = 3'd3,
    ST_L1_ADDR = 3'd4,
    ST_L1_CHR  = 3'd5
  } state_t;

  // Builds a 10-bit controller word: {RS, RW=0, byte}.
  function automatic logic [9:0] mk_word(input logic rs, input logic [7:0] b);
    logic [9:0] w;
    w         = '0;
    w[RS_BIT] = rs;
    w[RW_BIT] = 1'b0;
    w[7:0]    = b;
    return w;
  endfunction

endpackage

// File: rtl/char_store.sv
// char_store: 32x8 text store, resets to spaces, one sync write port, one comb read port.
// Latency: write visible the cycle after wr_en; read is combinational.
// Backpressure: none, a write is accepted every cycle.
// Ports: clk/reset (async active-low), wr_en/wr_addr/wr_char write port, rd_addr -> rd_char read port.
module char_store (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char
);

  logic [7:0] mem [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_char;
    end
  end

  // Combinational read: a same-cycle write to this address is not yet visible.
  assign rd_char = mem[rd_addr];

endmodule

// File: rtl/lcd_text_writer.sv
// lcd_text_writer: configures the LCD after reset, then repaints both lines whenever the text store changes.
// Latency: write in IDLE -> first screen word pushed two cycles later; one word per cycle when not full.
// Backpressure: req_buff_write = !full in emitting states; FSM holds with buffer_data stable while full.
// Ports: clk/reset (async active-low), wr_en/wr_addr/wr_char host text writes, full from the controller,
//        buffer_data/req_buff_write to the controller buffer, busy high outside IDLE.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter logic [7:0] CFG_FUNC  = 8'h28,
  parameter logic [7:0] CFG_ENTRY = 8'h06,
  parameter logic [7:0] CFG_DISP  = 8'h0C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       full,
  output logic [9:0] buffer_data,
  output logic       req_buff_write,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic       dirty;
  logic       enter_l0;
  logic       emit;
  logic       push;
  logic [9:0] word;
  logic [7:0] cfg_byte;
  logic [7:0] rd_char;

  char_store u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .rd_addr (idx),
    .rd_char (rd_char)
  );

  // Every state but IDLE emits a word. Outputs are forced quiet while reset is held.
  assign emit = (state == ST_CFG)     || (state == ST_L0_ADDR) || (state == ST_L0_CHR) ||
                (state == ST_L1_ADDR) || (state == ST_L1_CHR);
  assign push = reset && emit && !full;

  always_comb begin
    cfg_byte = CMD_CLEAR;
    case (idx[1:0])
      2'd0:    cfg_byte = CFG_FUNC;
      2'd1:    cfg_byte = CFG_ENTRY;
      2'd2:    cfg_byte = CFG_DISP;
      default: cfg_byte = CMD_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CFG;
      idx   <= 5'd0;
      dirty <= 1'b1;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      // A host write in the same cycle as the refresh start wins, forcing another refresh.
      if (wr_en)         dirty <= 1'b1;
      else if (enter_l0) dirty <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    enter_l0  = 1'b0;
    word      = '0;
    case (state)
      ST_CFG: begin
        word = mk_word(1'b0, cfg_byte);
        if (push) begin
          if (idx == 5'd3) begin
            state_nxt = ST_IDLE;
            idx_nxt   = 5'd0;
          end else begin
            idx_nxt = idx + 5'd1;
          end
        end
      end
      ST_IDLE: begin
        if (dirty) begin
          state_nxt = ST_L0_ADDR;
          idx_nxt   = 5'd0;
          enter_l0  = 1'b1;
        end
      end
      ST_L0_ADDR: begin
        word = mk_word(1'b0, CMD_LINE0);
        if (push) state_nxt = ST_L0_CHR;
      end
      ST_L0_CHR: begin
        word = mk_word(1'b1, rd_char);
        if (push) begin
          idx_nxt = idx + 5'd1;
          if (idx == 5'd15) state_nxt = ST_L1_ADDR;
        end
      end
      ST_L1_ADDR: begin
        // Index already sits at 16 and is held here.
        word = mk_word(1'b0, CMD_LINE1);
        if (push) state_nxt = ST_L1_CHR;
      end
      ST_L1_CHR: begin
        word = mk_word(1'b1, rd_char);
        if (push) begin
          idx_nxt = idx + 5'd1;
          if (idx == 5'd31) state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_CFG;
        idx_nxt   = 5'd0;
      end
    endcase
  end

  assign req_buff_write = push;
  assign buffer_data    = (reset && emit) ? word : 10'h000;
  assign busy           = !reset || (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_text_writer.sv
// tb_lcd_text_writer: directed self-checking bench for lcd_text_writer.
// Latency: n/a.
// Backpressure: drives full directly, including a fixed stall and a random toggle pattern.
module tb_lcd_text_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       full;
  logic [9:0] buffer_data;
  logic       req_buff_write;
  logic       busy;

  always #10 clk = ~clk;

  lcd_text_writer dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .full           (full),
    .buffer_data    (buffer_data),
    .req_buff_write (req_buff_write),
    .busy           (busy)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc;
  int         bad_push = 0;
  logic [9:0] pq[$];
  int         pc[$];
  logic [7:0] mstore[32];

  // Cycle number since reset release; cycle 0 is the first cycle with reset high.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record every push with its cycle; count any push made while full.
  always @(negedge clk) begin
    if (reset) begin
      if (req_buff_write) begin
        pq.push_back(buffer_data);
        pc.push_back(cyc);
      end
      if (req_buff_write && full) bad_push = bad_push + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] c, output int t);
    step();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_char = c;
    t       = cyc;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_pushes(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (pq.size() < n && k < bound) begin
      step();
      k++;
    end
    chk(tag, 32'(pq.size()), 32'(n));
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      step();
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic clear_q();
    pq.delete();
    pc.delete();
  endtask

  // One screen refresh: line-0 address, 16 chars, line-1 address, 16 chars.
  task automatic check_refresh(input string tag, input int base);
    logic [9:0] e;
    if (pq.size() < base + 34) begin
      chk($sformatf("%s_len", tag), 32'(pq.size()), 32'(base + 34));
      return;
    end
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       e = 10'h080;
      else if (i == 17) e = 10'h0C0;
      else if (i < 17)  e = {2'b10, mstore[i-1]};
      else              e = {2'b10, mstore[i-2]};
      chk($sformatf("%s_w%0d", tag, i), 32'(pq[base+i]), 32'(e));
    end
  endtask

  // Full boot sequence from reset release: 4 config words then one refresh, back-to-back.
  task automatic check_boot(input string tag);
    logic [9:0] cfgw[4];
    cfgw = '{10'h028, 10'h006, 10'h00C, 10'h001};
    wait_pushes(38, 100, {tag, "_count"});
    for (int i = 0; i < 4 && i < pq.size(); i++)
      chk($sformatf("%s_cfg%0d", tag, i), 32'(pq[i]), 32'(cfgw[i]));
    for (int i = 0; i < pc.size(); i++)
      chk($sformatf("%s_cyc%0d", tag, i), 32'(pc[i]), (i < 4) ? 32'(i) : 32'(i + 1));
    check_refresh({tag, "_ref"}, 4);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_idle_cycle"}, 32'(cyc), 32'd39);
  endtask

  initial begin
    int t;
    int t2;
    int k;
    reset   = 1'b0;
    full    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_char = 8'h00;
    for (int i = 0; i < 32; i++) mstore[i] = 8'h20;

    // Reset values held while reset is low.
    repeat (3) step();
    chk("rst_req", 32'(req_buff_write), 32'd0);
    chk("rst_data", 32'(buffer_data), 32'h000);
    chk("rst_busy", 32'(busy), 32'd1);

    // Boot: config + blank refresh.
    clear_q();
    step();
    reset = 1'b1;
    check_boot("boot");

    // 'H' at 0 and 'i' at 17. The second write lands after the refresh starts,
    // so it re-arms dirty and a second identical refresh follows.
    clear_q();
    write_char(5'd0, 8'h48, t);
    mstore[0] = 8'h48;
    write_char(5'd17, 8'h69, t2);
    mstore[17] = 8'h69;
    wait_pushes(68, 200, "hi_count");
    if (pc.size() > 0) chk("hi_latency", 32'(pc[0]), 32'(t + 2));
    if (pq.size() >= 20) begin
      chk("hi_word1", 32'(pq[1]), 32'h248);
      chk("hi_word19", 32'(pq[19]), 32'h269);
    end
    check_refresh("hi1", 0);
    check_refresh("hi2", 34);
    wait_idle(50);

    // Stall with full=1 for 5 cycles while char 4 ('4') is being offered.
    clear_q();
    write_char(5'd4, 8'h34, t);
    mstore[4] = 8'h34;
    repeat (6) step();
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_req%0d", i), 32'(req_buff_write), 32'd0);
      chk($sformatf("stall_data%0d", i), 32'(buffer_data), 32'h234);
      step();
    end
    full = 1'b0;
    wait_pushes(34, 100, "stall_count");
    wait_idle(50);
    chk("stall_total", 32'(pq.size()), 32'd34);
    check_refresh("stall", 0);

    // Collision: write 'A' to index 9 in the cycle index 9 is emitted.
    clear_q();
    write_char(5'd8, 8'h20, t);
    repeat (11) step();
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_char = 8'h41;
    step();
    wr_en   = 1'b0;
    wait_pushes(68, 200, "coll_count");
    if (pq.size() >= 45) begin
      chk("coll_old", 32'(pq[10]), 32'h220);
      chk("coll_new", 32'(pq[44]), 32'h241);
    end
    check_refresh("coll1", 0);
    mstore[9] = 8'h41;
    check_refresh("coll2", 34);
    wait_idle(50);

    // Reset at cycle 20 of a refresh.
    clear_q();
    write_char(5'd20, 8'h20, t);
    repeat (21) step();
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(req_buff_write), 32'd0);
    chk("midrst_data", 32'(buffer_data), 32'h000);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_partial", 32'(pq.size()), 32'd20);
    for (int i = 0; i < 32; i++) mstore[i] = 8'h20;
    step();
    clear_q();
    step();
    reset = 1'b1;
    check_boot("reboot");

    // Random full toggling over one refresh.
    clear_q();
    bad_push = 0;
    write_char(5'd31, 8'h7A, t);
    mstore[31] = 8'h7A;
    k = 0;
    while (pq.size() < 34 && k < 400) begin
      full = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    full = 1'b0;
    repeat (5) step();
    chk("rand_count", 32'(pq.size()), 32'd34);
    chk("rand_no_push_when_full", 32'(bad_push), 32'd0);
    check_refresh("rand", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
